icache_responder: RTL

//  Instruction-side responder of datapath_cache_if: answers the pipeline's imemREN/imemaddr

---
 rtl/icache_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/icache_responder.sv
// Direct-mapped, one-word-per-frame instruction cache answering the fetch stage.
// Misses fetch one word from RAM and fill the frame; hit/miss counters saturate.
module icache_responder #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  input  logic             halt,
  input  logic             iflush,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic [31:0]      iload,
  input  logic             iwait,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e             state_q, state_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [TAG_W-1:0]   tag_d  [SETS];
  logic [31:0]        data_q [SETS];
  logic [31:0]        data_d [SETS];
  logic [31:0]        miss_addr_q, miss_addr_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]     req_idx, fill_idx;
  logic [TAG_W-1:0]   req_tag, fill_tag;
  logic               req, hit, fill;
  logic               unused_byte_bits;

  assign req_idx          = imemaddr[IDX+1:2];
  assign req_tag          = imemaddr[31:IDX+2];
  assign fill_idx         = miss_addr_q[IDX+1:2];
  assign fill_tag         = miss_addr_q[31:IDX+2];
  assign unused_byte_bits = ^imemaddr[1:0];

  assign req  = imemREN && !halt;
  assign hit  = (state_q == IDLE) && req && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill = (state_q == FETCH) && !iwait;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req && !hit) state_d = FETCH;
      FETCH:   if (!iwait)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ihit     = hit;
    imemload = hit ? data_q[req_idx] : 32'h0;
    iREN     = (state_q == FETCH);
    iaddr    = (state_q == FETCH) ? miss_addr_q : 32'h0;
    hit_cnt  = hit_cnt_q;
    miss_cnt = miss_cnt_q;
  end

  // Flush is applied after the fill so a coincident flush leaves the frame invalid.
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    miss_addr_d = miss_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (hit && (hit_cnt_q != '1))
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    if ((state_q == IDLE) && req && !hit) begin
      miss_addr_d = {imemaddr[31:2], 2'b00};
      if (miss_cnt_q != '1)
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
    if (fill) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
      data_d[fill_idx]  = iload;
    end
    if (iflush)
      valid_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q     <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
